// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the 16-bit CPU.
// Owns the PC, reads imem one word at a time, feeds decode via a one-entry slot.
module fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [15:0] imem_rdata,
   output logic [15:0] instr,
   output logic [15:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_pc,
   output logic        halted
);

   typedef enum logic [1:0] {
      S_RUN,
      S_WAIT,
      S_DRAIN,
      S_HALTED
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] instr_q, instr_d;
   logic [15:0] ipc_q, ipc_d;
   logic        slot_q, slot_d;
   logic        hpend_q, hpend_d;
   logic        xfer;
   logic        slot_halt;

   assign instr       = instr_q;
   assign instr_pc    = ipc_q;
   assign instr_valid = slot_q & ~redirect_valid;
   assign xfer        = instr_valid & instr_ready;
   assign slot_halt   = (instr_q[15:12] == 4'hF);
   assign imem_addr   = pc_q;
   assign halted      = (state_q == S_HALTED);

   // Request only when the slot will be empty, so it can never overflow.
   assign imem_req = ~rst & (state_q == S_RUN) & ~hpend_q
                   & (~slot_q | xfer);

   // Next-state logic: redirect wins, then HALT consumption, then fetch.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      slot_d  = slot_q;
      hpend_d = hpend_q;
      if (state_q == S_HALTED) begin
         state_d = S_HALTED;
      end else if (redirect_valid) begin
         pc_d    = redirect_pc;
         slot_d  = 1'b0;
         hpend_d = 1'b0;
         case (state_q)
            S_RUN:
               if (imem_req & imem_gnt)
                  state_d = S_DRAIN;
            S_WAIT, S_DRAIN:
               state_d = imem_rvalid ? S_RUN : S_DRAIN;
            default:
               state_d = state_q;
         endcase
      end else if (xfer & slot_halt) begin
         slot_d  = 1'b0;
         state_d = S_HALTED;
      end else begin
         if (xfer)
            slot_d = 1'b0;
         case (state_q)
            S_RUN:
               if (imem_req & imem_gnt) begin
                  pc_d    = pc_q + 16'd1;
                  state_d = S_WAIT;
               end
            S_WAIT:
               if (imem_rvalid) begin
                  instr_d = imem_rdata;
                  ipc_d   = pc_q - 16'd1;
                  slot_d  = 1'b1;
                  if (imem_rdata[15:12] == 4'hF)
                     hpend_d = 1'b1;
                  state_d = S_RUN;
               end
            S_DRAIN:
               if (imem_rvalid)
                  state_d = S_RUN;
            default:
               state_d = state_q;
         endcase
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_RUN;
         pc_q    <= RESET_PC;
         instr_q <= 16'h0000;
         ipc_q   <= 16'h0000;
         slot_q  <= 1'b0;
         hpend_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
         slot_q  <= slot_d;
         hpend_q <= hpend_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random checks of fetch_unit against a
// stream-level model (expected decode PC, fetch pointer, halt flag).
module tb_fetch_unit;
   localparam logic [15:0] RPC = 16'h0010;

   logic        clk, rst;
   logic        imem_req, imem_gnt, imem_rvalid;
   logic [15:0] imem_addr, imem_rdata;
   logic [15:0] instr, instr_pc, redirect_pc;
   logic        instr_valid, instr_ready;
   logic        redirect_valid, halted;

   fetch_unit #(.RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata),
      .instr(instr), .instr_pc(instr_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int gnt_pol = 0;
   int lat_lo = 1;
   int lat_hi = 1;
   int n_xfer = 0;
   int xfer_cyc [$];
   logic [15:0] mem_ov [logic [15:0]];
   logic [15:0] q_addr [$];
   int          q_cnt [$];

   // model state
   logic [15:0] exp_pc, fetch_ptr;
   logic        m_halted = 1'b0;
   logic        p_rst = 1'b1;
   logic        p_hold = 1'b0;
   logic [15:0] p_addr = '0;

   // per-cycle samples
   logic        s_req, s_gnt, s_rvalid, s_valid, s_xfer, s_halted = 1'b0;
   logic [15:0] s_addr, s_instr, s_pc;

   function automatic logic [15:0] memword(input logic [15:0] a);
      logic [15:0] t;
      if (mem_ov.exists(a))
         return mem_ov[a];
      t = (a * 16'd7 + 16'd3) % 16'd15;
      return {t[3:0], a[11:0] ^ 12'h5A5};
   endfunction

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      n_vec++;
      assert (got === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic got, input logic exp);
      n_vec++;
      assert (got === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
   endtask

   // Compare the cycle's outputs with the model, then advance the model.
   task automatic monitor();
      logic halt_now;
      halt_now = 1'b0;
      if (rst) begin
         chk1("req_in_rst", imem_req, 1'b0);
         q_addr.delete();
         q_cnt.delete();
         exp_pc = RPC;
         fetch_ptr = RPC;
         m_halted = 1'b0;
         p_rst = 1'b1;
         p_hold = 1'b0;
         return;
      end
      if (p_rst)
         chk1("req_after_rst", imem_req, 1'b1);
      chk1("halted", halted, m_halted);
      if (redirect_valid)
         chk1("valid_on_redirect", instr_valid, 1'b0);
      if (m_halted)
         chk1("req_when_halted", imem_req, 1'b0);
      if (imem_req)
         chk("one_outstanding", 16'(q_addr.size()), 16'd0);
      if (p_hold && imem_req)
         chk("addr_stable", imem_addr, p_addr);
      if (s_xfer) begin
         chk("xfer_pc", instr_pc, exp_pc);
         chk("xfer_instr", instr, memword(exp_pc));
         if (memword(exp_pc) >= 16'hF000)
            halt_now = 1'b1;
         exp_pc = exp_pc + 16'd1;
         n_xfer++;
         xfer_cyc.push_back(cyc);
      end
      if (imem_req && imem_gnt) begin
         chk("fetch_addr", imem_addr, fetch_ptr);
         fetch_ptr = fetch_ptr + 16'd1;
      end
      if (redirect_valid && !m_halted) begin
         exp_pc = redirect_pc;
         fetch_ptr = redirect_pc;
      end
      if (halt_now)
         m_halted = 1'b1;
      if (imem_rvalid) begin
         void'(q_addr.pop_front());
         void'(q_cnt.pop_front());
      end
      foreach (q_cnt[i])
         q_cnt[i]--;
      if (imem_gnt) begin
         q_addr.push_back(imem_addr);
         q_cnt.push_back($urandom_range(lat_lo, lat_hi) - 1);
      end
      p_hold = imem_req && !imem_gnt && !redirect_valid;
      p_addr = imem_addr;
      p_rst = 1'b0;
   endtask

   // One clock: drive memory, sample on negedge, return at posedge+1.
   task automatic tick();
      #1;
      imem_rvalid = 1'b0;
      imem_rdata = '0;
      if (q_cnt.size() > 0 && q_cnt[0] == 0) begin
         imem_rvalid = 1'b1;
         imem_rdata = memword(q_addr[0]);
      end
      imem_gnt = imem_req && ($urandom_range(0, gnt_pol) == 0);
      @(negedge clk);
      s_req = imem_req;
      s_gnt = imem_gnt;
      s_rvalid = imem_rvalid;
      s_valid = instr_valid;
      s_xfer = instr_valid && instr_ready;
      s_halted = halted;
      s_addr = imem_addr;
      s_instr = instr;
      s_pc = instr_pc;
      monitor();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) tick();
      rst = 1'b0;
   endtask

   task automatic redirect(input logic [15:0] t);
      redirect_valid = 1'b1;
      redirect_pc = t;
      tick();
      redirect_valid = 1'b0;
   endtask

   // what: 0 transfer, 1 grant, 2 slot valid
   task automatic wait_for(input int what, input string tag);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 60 && !hit; i++) begin
         tick();
         case (what)
            0:       hit = s_xfer;
            1:       hit = s_req && s_gnt;
            default: hit = s_valid;
         endcase
      end
      chk1({"reach_", tag}, hit, 1'b1);
   endtask

   initial begin
      int c0;
      int hreq;
      logic hseen;
      rst = 1'b1;
      instr_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata = '0;
      mem_ov[16'h0010] = 16'h0123;
      mem_ov[16'h0011] = 16'h5101;
      mem_ov[16'h0012] = 16'h3222;
      mem_ov[16'h0030] = 16'h0001;
      mem_ov[16'h0031] = 16'hF000;
      mem_ov[16'h0032] = 16'h0002;
      mem_ov[16'h0040] = 16'hF000;
      @(posedge clk);
      #1;
      do_reset(2);

      // reset state and sequential fetch, 1-cycle memory
      c0 = cyc;
      tick();
      chk("rst_addr", s_addr, RPC);
      chk("rst_instr", s_instr, 16'h0000);
      chk("rst_ipc", s_pc, 16'h0000);
      chk1("rst_valid", s_valid, 1'b0);
      wait_for(0, "x10");
      wait_for(0, "x11");
      wait_for(0, "x12");
      chk("seq_count", 16'(xfer_cyc.size()), 16'd3);
      if (xfer_cyc.size() == 3) begin
         chk("seq_first", 16'(xfer_cyc[0] - c0), 16'd2);
         chk("seq_gap1", 16'(xfer_cyc[1] - xfer_cyc[0]), 16'd2);
         chk("seq_gap2", 16'(xfer_cyc[2] - xfer_cyc[1]), 16'd2);
      end

      // decode stall with 16'h5101 in the slot
      do_reset(1);
      wait_for(0, "stall_x10");
      instr_ready = 1'b0;
      wait_for(2, "stall_fill");
      chk("stall_instr", s_instr, 16'h5101);
      chk1("stall_req", s_req, 1'b0);
      repeat (4) begin
         tick();
         chk("stall_instr", s_instr, 16'h5101);
         chk1("stall_req", s_req, 1'b0);
      end
      instr_ready = 1'b1;
      tick();
      chk1("release_xfer", s_xfer, 1'b1);
      chk1("release_req", s_req, 1'b1);

      // redirect while waiting on a 3-cycle memory
      lat_lo = 3;
      lat_hi = 3;
      redirect(16'h0020);
      wait_for(1, "g20");
      chk("g20_addr", s_addr, 16'h0020);
      redirect(16'h0100);
      wait_for(1, "g100");
      chk("g100_addr", s_addr, 16'h0100);
      wait_for(0, "x100");
      chk("x100_pc", s_pc, 16'h0100);

      // redirect coinciding with grant, then with rvalid
      lat_lo = 1;
      lat_hi = 1;
      do_reset(1);
      redirect(16'h0200);
      chk1("sim_gnt", s_gnt, 1'b1);
      wait_for(0, "x200a");
      chk("x200a_pc", s_pc, 16'h0200);
      wait_for(1, "g_pre");
      redirect(16'h0200);
      chk1("sim_rvalid", s_rvalid, 1'b1);
      wait_for(0, "x200b");
      chk("x200b_pc", s_pc, 16'h0200);

      // HALT
      redirect(16'h0030);
      hseen = 1'b0;
      hreq = 0;
      for (int i = 0; i < 40 && !s_halted; i++) begin
         tick();
         if (hseen && s_req)
            hreq++;
         if (s_gnt && s_addr == 16'h0031)
            hseen = 1'b1;
      end
      chk1("halt_reached", s_halted, 1'b1);
      chk1("halt_fetched", hseen, 1'b1);
      for (int i = 0; i < 7; i++) begin
         redirect_valid = (i == 3);
         redirect_pc = 16'h0000;
         tick();
         if (s_req)
            hreq++;
      end
      redirect_valid = 1'b0;
      chk("halt_no_req", 16'(hreq), 16'd0);
      chk1("halt_sticky", s_halted, 1'b1);
      do_reset(1);
      tick();
      chk("restart_addr", s_addr, RPC);
      chk1("restart_halted", s_halted, 1'b0);

      // PC wrap
      redirect(16'hFFFF);
      wait_for(1, "gFFFF");
      chk("gFFFF_addr", s_addr, 16'hFFFF);
      wait_for(1, "g0000");
      chk("wrap_addr", s_addr, 16'h0000);

      // HALT in the slot flushed by a redirect
      instr_ready = 1'b0;
      redirect(16'h0040);
      wait_for(2, "hold_f000");
      chk("hold_instr", s_instr, 16'hF000);
      tick();
      chk1("hold_req", s_req, 1'b0);
      redirect(16'h0050);
      instr_ready = 1'b1;
      wait_for(0, "x50");
      chk("x50_pc", s_pc, 16'h0050);
      chk1("flush_halted", s_halted, 1'b0);

      // random traffic
      lat_lo = 1;
      lat_hi = 4;
      for (int i = 0; i < 3000; i++) begin
         instr_ready = ($urandom_range(0, 3) != 0);
         gnt_pol = $urandom_range(0, 2);
         rst = ($urandom_range(0, 199) == 0)
            || (m_halted && $urandom_range(0, 7) == 0);
         redirect_valid = !rst && ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 1) == 0)
            redirect_pc = 16'($urandom);
         else
            redirect_pc = 16'($urandom_range(16'h002C, 16'h0042));
         tick();
      end
      rst = 1'b0;
      redirect_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
